// File: rtl/proc_pkg.sv
// Shared definitions for the 4-bit-opcode pipeline.
// Holds opcode encodings, immediate extension helpers and the writeback predicate.
package proc_pkg;

  localparam logic [3:0] OP_HLT = 4'b0000;
  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_MVI = 4'b0010;
  localparam logic [3:0] OP_LOD = 4'b0011;
  localparam logic [3:0] OP_STR = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_ORR = 4'b1001;
  localparam logic [3:0] OP_NOT = 4'b1010;
  localparam logic [3:0] OP_LES = 4'b1011;
  localparam logic [3:0] OP_GTR = 4'b1100;
  localparam logic [3:0] OP_JEZ = 4'b1101;
  localparam logic [3:0] OP_JNZ = 4'b1110;
  localparam logic [3:0] OP_JMP = 4'b1111;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_state_e;

  function automatic logic [31:0] sext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zext(input logic [15:0] imm);
    return {16'b0, imm};
  endfunction

  // MOV, MVI, LOD and the contiguous ADD..GTR block write a register.
  function automatic logic is_reg_write(input logic [3:0] op);
    return (op == OP_MOV) || (op == OP_MVI) || (op == OP_LOD) ||
           ((op >= OP_ADD) && (op <= OP_GTR));
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Decode-to-execute-to-memory bundle. The decode side drives id_* and mem_stall
// (master); the execute stage consumes them and drives the ex_* results (slave).
interface ex_stage_if #(
  parameter int DATA_W = 32
);
  logic              id_valid;
  logic [3:0]        id_opcode;
  logic [DATA_W-1:0] id_pc;
  logic [3:0]        id_rd_idx;
  logic [DATA_W-1:0] id_rdest;
  logic [DATA_W-1:0] id_ra;
  logic [DATA_W-1:0] id_rb;
  logic [15:0]       id_immediate;
  logic              mem_stall;

  logic              ex_stall;
  logic              ex_valid;
  logic [3:0]        ex_opcode;
  logic [3:0]        ex_rd_idx;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic              ex_reg_write;
  logic              branch_taken;
  logic [DATA_W-1:0] branch_target;
  logic              halted;

  modport master (
    output id_valid, id_opcode, id_pc, id_rd_idx, id_rdest, id_ra, id_rb,
           id_immediate, mem_stall,
    input  ex_stall, ex_valid, ex_opcode, ex_rd_idx, ex_alu_result,
           ex_store_data, ex_reg_write, branch_taken, branch_target, halted
  );

  modport slave (
    input  id_valid, id_opcode, id_pc, id_rd_idx, id_rdest, id_ra, id_rb,
           id_immediate, mem_stall,
    output ex_stall, ex_valid, ex_opcode, ex_rd_idx, ex_alu_result,
           ex_store_data, ex_reg_write, branch_taken, branch_target, halted
  );
endinterface

// File: rtl/ex_alu.sv
// Combinational ALU for every single-cycle opcode; MUL, HLT and branches yield 0 here.
module ex_alu import proc_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        opcode_i,
  input  logic [DATA_W-1:0] ra_i,
  input  logic [DATA_W-1:0] rb_i,
  input  logic [15:0]       imm_i,
  output logic [DATA_W-1:0] result_o
);

  logic [DATA_W-1:0] immSext;

  assign immSext = DATA_W'(sext(imm_i));

  // LES/GTR are unsigned compares zero-extended to a full word.
  always_comb begin
    result_o = '0;
    case (opcode_i)
      OP_MOV:         result_o = ra_i;
      OP_MVI:         result_o = immSext;
      OP_LOD, OP_STR: result_o = ra_i + immSext;
      OP_ADD:         result_o = ra_i + rb_i;
      OP_SUB:         result_o = ra_i - rb_i;
      OP_AND:         result_o = ra_i & rb_i;
      OP_ORR:         result_o = ra_i | rb_i;
      OP_NOT:         result_o = ~ra_i;
      OP_LES:         result_o = DATA_W'(ra_i < rb_i);
      OP_GTR:         result_o = DATA_W'(ra_i > rb_i);
      default:        result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU path, multi-cycle MUL sequencer that stalls decode,
// branch resolution with a post-branch squash window, and a sticky halt.
module ex_stage import proc_pkg::*; #(
  parameter int DATA_W        = 32,
  parameter int MUL_CYCLES    = 3,
  parameter int BRANCH_SHADOW = 1
) (
  input logic       clock,
  input logic       reset_n,
  ex_stage_if.slave bus
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int SQ_W  = (BRANCH_SHADOW > 0) ? $clog2(BRANCH_SHADOW + 1) : 1;

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SQ_W-1:0]   squash_q, squash_d;
  logic              halted_q, halted_d;
  logic [DATA_W-1:0] mulA_q, mulA_d;
  logic [DATA_W-1:0] mulB_q, mulB_d;
  logic [3:0]        mulRd_q, mulRd_d;

  logic              valid_q, valid_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [3:0]        rd_q, rd_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic              regWr_q, regWr_d;
  logic              brTaken_q, brTaken_d;
  logic [DATA_W-1:0] brTarget_q, brTarget_d;

  logic [DATA_W-1:0] aluResult;
  logic              exStall, accept, drop, issue, brCond, isMul;

  ex_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode_i (bus.id_opcode),
    .ra_i     (bus.id_ra),
    .rb_i     (bus.id_rb),
    .imm_i    (bus.id_immediate),
    .result_o (aluResult)
  );

  assign exStall = (state_q == MUL_BUSY);
  assign accept  = bus.id_valid & ~bus.mem_stall & ~exStall & ~halted_q;
  assign drop    = accept & (squash_q != '0);
  assign issue   = accept & ~drop;
  assign isMul   = (bus.id_opcode == OP_MUL);

  always_comb begin
    brCond = 1'b0;
    case (bus.id_opcode)
      OP_JMP:  brCond = 1'b1;
      OP_JEZ:  brCond = (bus.id_rdest == '0);
      OP_JNZ:  brCond = (bus.id_rdest != '0);
      default: brCond = 1'b0;
    endcase
  end

  // Under mem_stall everything holds except the redirect, which is a single pulse.
  // Otherwise an idle cycle clears the outputs so stale results never look valid.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    squash_d   = squash_q;
    halted_d   = halted_q;
    mulA_d     = mulA_q;
    mulB_d     = mulB_q;
    mulRd_d    = mulRd_q;
    valid_d    = valid_q;
    opcode_d   = opcode_q;
    rd_d       = rd_q;
    result_d   = result_q;
    store_d    = store_q;
    regWr_d    = regWr_q;
    brTaken_d  = 1'b0;
    brTarget_d = '0;

    if (!bus.mem_stall) begin
      valid_d  = 1'b0;
      opcode_d = '0;
      rd_d     = '0;
      result_d = '0;
      store_d  = '0;
      regWr_d  = 1'b0;

      if (state_q == MUL_BUSY) begin
        if (cnt_q == CNT_W'(1)) begin
          state_d  = MUL_DONE;
          cnt_d    = '0;
          valid_d  = 1'b1;
          opcode_d = OP_MUL;
          rd_d     = mulRd_q;
          result_d = mulA_q * mulB_q;
          regWr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else begin
        state_d = MUL_IDLE;
        if (drop) begin
          squash_d = squash_q - SQ_W'(1);
        end else if (issue) begin
          if (isMul && (MUL_CYCLES > 1)) begin
            state_d = MUL_BUSY;
            cnt_d   = CNT_W'(MUL_CYCLES - 1);
            mulA_d  = bus.id_ra;
            mulB_d  = bus.id_rb;
            mulRd_d = bus.id_rd_idx;
          end else begin
            valid_d  = 1'b1;
            opcode_d = bus.id_opcode;
            rd_d     = bus.id_rd_idx;
            result_d = isMul ? bus.id_ra * bus.id_rb : aluResult;
            store_d  = (bus.id_opcode == OP_STR) ? bus.id_rdest : '0;
            regWr_d  = is_reg_write(bus.id_opcode);
            if (bus.id_opcode == OP_HLT) begin
              halted_d = 1'b1;
            end
            if (brCond) begin
              brTaken_d  = 1'b1;
              brTarget_d = DATA_W'(zext(bus.id_immediate));
              squash_d   = SQ_W'(BRANCH_SHADOW);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= MUL_IDLE;
      cnt_q      <= '0;
      squash_q   <= '0;
      halted_q   <= 1'b0;
      mulA_q     <= '0;
      mulB_q     <= '0;
      mulRd_q    <= '0;
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      rd_q       <= '0;
      result_q   <= '0;
      store_q    <= '0;
      regWr_q    <= 1'b0;
      brTaken_q  <= 1'b0;
      brTarget_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      squash_q   <= squash_d;
      halted_q   <= halted_d;
      mulA_q     <= mulA_d;
      mulB_q     <= mulB_d;
      mulRd_q    <= mulRd_d;
      valid_q    <= valid_d;
      opcode_q   <= opcode_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      store_q    <= store_d;
      regWr_q    <= regWr_d;
      brTaken_q  <= brTaken_d;
      brTarget_q <= brTarget_d;
    end
  end

  assign bus.ex_stall      = exStall;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_opcode     = opcode_q;
  assign bus.ex_rd_idx     = rd_q;
  assign bus.ex_alu_result = result_q;
  assign bus.ex_store_data = store_q;
  assign bus.ex_reg_write  = regWr_q;
  assign bus.branch_taken  = brTaken_q;
  assign bus.branch_target = brTarget_q;
  assign bus.halted        = halted_q;

endmodule
